// File: rtl/wb_interconnect.sv
// Single-master Wishbone interconnect: address decode onto 16 slave strobes,
// acknowledge/read-data mux, and a watchdog that bus-errors stalled transfers.
module wb_interconnect #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic         clk,
  input  logic         RSTN,
  input  logic         master_STB,
  input  logic         master_WE,
  input  logic [31:0]  master_ADDR,
  input  logic [31:0]  master_DAT_I,
  output logic [31:0]  master_DAT_O,
  output logic         master_ACK,
  output logic         bus_err,
  output logic [16:0]  slave_STB,
  input  logic [16:0]  slave_ACK,
  output logic         slave_WE,
  output logic [31:0]  slave_ADDR,
  output logic [31:0]  slave_DAT_O,
  input  logic [511:0] slave_DAT_I
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  logic [3:0]  sel_s;
  logic        req_s;
  logic        sel_ack_s;
  logic        to_s;
  logic [31:0] sel_dat_s;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  assign sel_s     = master_ADDR[31:28];
  assign req_s     = RSTN & master_STB;
  // Bit 16 of slave_ACK is unreachable because sel is only 4 bits wide.
  assign sel_ack_s = slave_ACK[{1'b0, sel_s}];
  assign sel_dat_s = slave_DAT_I[{sel_s, 5'd0} +: 32];
  // A real slave acknowledge in the timeout cycle wins over the watchdog.
  assign to_s      = req_s & ~sel_ack_s & (cnt_q == TIMEOUT_C);

  assign slave_WE    = master_WE;
  assign slave_ADDR  = master_ADDR;
  assign slave_DAT_O = master_DAT_I;

  // One-hot strobe decode, reserved bit 16 held low.
  always_comb begin
    slave_STB = 17'd0;
    for (int i = 0; i < 16; i++) begin
      if (req_s && (sel_s == 4'(i))) begin
        slave_STB[i] = 1'b1;
      end else begin
        slave_STB[i] = 1'b0;
      end
    end
  end

  // Acknowledge, bus error and read-data selection.
  always_comb begin
    master_ACK   = req_s & (sel_ack_s | to_s);
    bus_err      = to_s;
    master_DAT_O = sel_dat_s;
    if (to_s) begin
      master_DAT_O = ERR_DATA;
    end else begin
      master_DAT_O = sel_dat_s;
    end
  end

  // Watchdog next state: clear on idle or any acknowledge, otherwise saturating count.
  always_comb begin
    cnt_d = cnt_q;
    if (!master_STB || master_ACK) begin
      cnt_d = 16'd0;
    end else if (cnt_q == 16'hFFFF) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Directed bench for wb_interconnect (TIMEOUT=4): single-cycle vector table
// plus sequences for watchdog, race, level-held ACK, re-decode and reset abort.
module tb_wb_interconnect;

  logic         clk;
  logic         RSTN;
  logic         master_STB;
  logic         master_WE;
  logic [31:0]  master_ADDR;
  logic [31:0]  master_DAT_I;
  logic [31:0]  master_DAT_O;
  logic         master_ACK;
  logic         bus_err;
  logic [16:0]  slave_STB;
  logic [16:0]  slave_ACK;
  logic         slave_WE;
  logic [31:0]  slave_ADDR;
  logic [31:0]  slave_DAT_O;
  logic [511:0] slave_DAT_I;

  int n_checks;
  int n_fail;

  wb_interconnect #(.TIMEOUT(4), .ERR_DATA(32'hFFFF_FFFF)) dut (
    .clk(clk), .RSTN(RSTN),
    .master_STB(master_STB), .master_WE(master_WE), .master_ADDR(master_ADDR),
    .master_DAT_I(master_DAT_I), .master_DAT_O(master_DAT_O), .master_ACK(master_ACK),
    .bus_err(bus_err), .slave_STB(slave_STB), .slave_ACK(slave_ACK), .slave_WE(slave_WE),
    .slave_ADDR(slave_ADDR), .slave_DAT_O(slave_DAT_O), .slave_DAT_I(slave_DAT_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [16:0] ack;
    logic [16:0] e_stb;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dato;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Checks master-side response and strobe vector for the current cycle.
  task automatic chk_cyc(input string tag, input logic [16:0] e_stb, input logic e_ack,
                         input logic e_err, input logic [31:0] e_dato);
    chk({tag, " slave_STB"}, {15'd0, slave_STB}, {15'd0, e_stb});
    chk({tag, " master_ACK"}, {31'd0, master_ACK}, {31'd0, e_ack});
    chk({tag, " bus_err"}, {31'd0, bus_err}, {31'd0, e_err});
    chk({tag, " master_DAT_O"}, master_DAT_O, e_dato);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) begin
      slave_DAT_I[32*i +: 32] = 32'hC0DE_0000 | 32'(i);
    end
    slave_DAT_I[31:0] = 32'h1234_5678;

    //        stb   we    addr           dat            ack        e_stb      eack  eerr  e_dato
    vecs[0] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 17'h00001, 17'h00001, 1'b1, 1'b0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b1, 32'h4000_0000, 32'hA5A5_A5A5, 17'h00010, 17'h00010, 1'b1, 1'b0, 32'hC0DE_0004};
    vecs[2] = '{1'b1, 1'b1, 32'h4000_0000, 32'hA5A5_A5A5, 17'h00000, 17'h00010, 1'b0, 1'b0, 32'hC0DE_0004};
    vecs[3] = '{1'b1, 1'b0, 32'h3000_0000, 32'h0000_0000, 17'h00001, 17'h00008, 1'b0, 1'b0, 32'hC0DE_0003};
    vecs[4] = '{1'b1, 1'b0, 32'hF000_0000, 32'h0000_0000, 17'h10000, 17'h08000, 1'b0, 1'b0, 32'hC0DE_000F};
    vecs[5] = '{1'b0, 1'b0, 32'h2000_0000, 32'h0000_0000, 17'h00004, 17'h00000, 1'b0, 1'b0, 32'hC0DE_0002};
    vecs[6] = '{1'b1, 1'b0, 32'h2ABC_0000, 32'h0000_0000, 17'h00004, 17'h00004, 1'b1, 1'b0, 32'hC0DE_0002};
    vecs[7] = '{1'b1, 1'b1, 32'h1000_0004, 32'h5A5A_0001, 17'h1FFFF, 17'h00002, 1'b1, 1'b0, 32'hC0DE_0001};

    // Reset state with an active request and acknowledge present.
    RSTN = 1'b0; master_STB = 1'b1; master_WE = 1'b1;
    master_ADDR = 32'h0000_0020; master_DAT_I = 32'hDEAD_BEEF; slave_ACK = 17'h00001;
    #2;
    chk_cyc("reset", 17'h00000, 1'b0, 1'b0, 32'h1234_5678);
    chk("reset slave_ADDR", slave_ADDR, 32'h0000_0020);
    chk("reset slave_DAT_O", slave_DAT_O, 32'hDEAD_BEEF);
    chk("reset slave_WE", {31'd0, slave_WE}, 32'd1);
    @(negedge clk);
    RSTN = 1'b1; master_STB = 1'b0; slave_ACK = 17'h0;
    @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      master_STB = vecs[v].stb; master_WE = vecs[v].we; master_ADDR = vecs[v].addr;
      master_DAT_I = vecs[v].dat; slave_ACK = vecs[v].ack;
      #1;
      chk_cyc($sformatf("vec%0d", v), vecs[v].e_stb, vecs[v].e_ack, vecs[v].e_err, vecs[v].e_dato);
      chk($sformatf("vec%0d slave_WE", v), {31'd0, slave_WE}, {31'd0, vecs[v].we});
      chk($sformatf("vec%0d slave_ADDR", v), slave_ADDR, vecs[v].addr);
      chk($sformatf("vec%0d slave_DAT_O", v), slave_DAT_O, vecs[v].dat);
      @(negedge clk);
      master_STB = 1'b0; slave_ACK = 17'h0;
      @(negedge clk);
    end

    // Watchdog: no ACK on unpopulated slave 15, error in cycles 5 and 10.
    master_STB = 1'b1; master_WE = 1'b0; master_ADDR = 32'hF000_0000; slave_ACK = 17'h0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (c == 5 || c == 10) chk_cyc($sformatf("timeout c%0d", c), 17'h08000, 1'b1, 1'b1, 32'hFFFF_FFFF);
      else                   chk_cyc($sformatf("timeout c%0d", c), 17'h08000, 1'b0, 1'b0, 32'hC0DE_000F);
      @(negedge clk);
    end
    master_STB = 1'b0;
    @(negedge clk);

    // Race: slave ACK arrives exactly in the cnt==TIMEOUT cycle, then counting restarts.
    master_STB = 1'b1; master_ADDR = 32'hF000_0000;
    for (int c = 1; c <= 9; c++) begin
      slave_ACK = (c == 5) ? 17'h08000 : 17'h00000;
      #1;
      if (c == 5)      chk_cyc("race c5", 17'h08000, 1'b1, 1'b0, 32'hC0DE_000F);
      else if (c == 9) chk_cyc("race c9", 17'h08000, 1'b0, 1'b0, 32'hC0DE_000F);
      else if (c == 6) chk_cyc("race c6", 17'h08000, 1'b0, 1'b0, 32'hC0DE_000F);
      @(negedge clk);
    end
    // Cycle 10 of this run is cnt==4 after the race-cleared count.
    #1;
    chk_cyc("race c10", 17'h08000, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clk);
    master_STB = 1'b0; slave_ACK = 17'h0;
    @(negedge clk);

    // Level-held handshake: ACK every cycle for 6 cycles, never a bus error.
    master_STB = 1'b1; master_ADDR = 32'h2000_0100; slave_ACK = 17'h00004;
    for (int c = 1; c <= 6; c++) begin
      #1;
      chk_cyc($sformatf("held c%0d", c), 17'h00004, 1'b1, 1'b0, 32'hC0DE_0002);
      @(negedge clk);
    end
    master_STB = 1'b0; slave_ACK = 17'h0;
    @(negedge clk);

    // Address change mid-transfer re-decodes but keeps the count.
    master_STB = 1'b1; master_ADDR = 32'h5000_0000;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) master_ADDR = 32'h6000_0000;
      #1;
      if (c == 2)      chk_cyc("redecode c2", 17'h00020, 1'b0, 1'b0, 32'hC0DE_0005);
      else if (c == 3) chk_cyc("redecode c3", 17'h00040, 1'b0, 1'b0, 32'hC0DE_0006);
      else if (c == 5) chk_cyc("redecode c5", 17'h00040, 1'b1, 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
    end
    master_STB = 1'b0;
    @(negedge clk);

    // Reset abort at cnt==3, then full TIMEOUT wait after release.
    master_STB = 1'b1; master_ADDR = 32'h7000_0000;
    for (int c = 1; c <= 3; c++) @(negedge clk);
    #1;
    RSTN = 1'b0;
    #1;
    chk_cyc("rst abort", 17'h00000, 1'b0, 1'b0, 32'hC0DE_0007);
    @(negedge clk);
    RSTN = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      #1;
      if (c == 5) chk_cyc("post-rst c5", 17'h00080, 1'b1, 1'b1, 32'hFFFF_FFFF);
      else        chk_cyc($sformatf("post-rst c%0d", c), 17'h00080, 1'b0, 1'b0, 32'hC0DE_0007);
      @(negedge clk);
    end
    master_STB = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
